// File: rtl/pbus_decoder_fsm_if.sv
// PBUS decoder bus bundle: master-side handshake plus the flattened slave-side
// data/ack/err/strobe vectors. The decoder connects via the 'slave' modport;
// the BIU/peripheral side (or a bench) drives it through 'master'.
interface pbus_decoder_fsm_if #(
    parameter int N_SLAVES = 8
);
    logic [31:0]            m_adr;
    logic                   m_cyc;
    logic                   m_stb;
    logic [31:0]            m_dat;
    logic                   m_ack;
    logic                   m_err;
    logic [32*N_SLAVES-1:0] s_dat;
    logic [N_SLAVES-1:0]    s_ack;
    logic [N_SLAVES-1:0]    s_err;
    logic [N_SLAVES-1:0]    cs;

    modport slave (
        input  m_adr, m_cyc, m_stb, s_dat, s_ack, s_err,
        output m_dat, m_ack, m_err, cs
    );

    modport master (
        output m_adr, m_cyc, m_stb, s_dat, s_ack, s_err,
        input  m_dat, m_ack, m_err, cs
    );
endinterface

// File: rtl/pbus_decoder_fsm.sv
// PBUS address decoder / response mux. Decodes the master address against
// per-slave base/mask pairs, latches the winner for the whole cycle, passes
// that slave's data/ack/err straight back, and terminates unmapped or stalled
// cycles with an error of its own. A one-cycle DONE gap after every cycle keeps
// a lingering strobe from being decoded twice.
module pbus_decoder_fsm #(
    parameter int                      N_SLAVES   = 8,
    parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK = {N_SLAVES{32'hF000_0000}},
    parameter int                      TIMEOUT    = 255,
    parameter int                      CNT_W      = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    pbus_decoder_fsm_if.slave   bus,
    output logic                adr_err_o,
    output logic                timeout_o,
    output logic [31:0]         err_adr_o
);

    localparam int               SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // Counter value seen on the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERR    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [31:0]         r_err_adr;
    logic [31:0]         w_err_adr_nxt;

    logic [N_SLAVES-1:0] w_match;
    logic [31:0]         w_sdat [N_SLAVES];
    logic                w_hit;
    logic [SEL_W-1:0]    w_win;
    logic                w_req;
    logic                w_sack;
    logic                w_serr;

    logic [N_SLAVES-1:0] w_cs;
    logic [31:0]         w_dat;
    logic                w_ack;
    logic                w_err;
    logic                w_adr_err;
    logic                w_tmo;

    // Per-slave address compare and unflattened read data.
    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_slv
            assign w_match[gi] = (bus.m_adr & SLAVE_MASK[32*gi +: 32]) ==
                                 (SLAVE_BASE[32*gi +: 32] & SLAVE_MASK[32*gi +: 32]);
            assign w_sdat[gi]  = bus.s_dat[32*gi +: 32];
        end
    endgenerate

    assign w_req  = bus.m_cyc & bus.m_stb;
    assign w_sack = bus.s_ack[r_sel];
    assign w_serr = bus.s_err[r_sel];

    // Priority encode the matches: scanning downward leaves the lowest index.
    always_comb begin
        w_win = '0;
        w_hit = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_win = SEL_W'(i);
                w_hit = 1'b1;
            end
        end
    end

    // State, selected slave, watchdog and error address registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_err_adr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err_adr <= w_err_adr_nxt;
        end
    end

    // Next-state logic and bus outputs; responses pass through with no added latency.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_err_adr_nxt = r_err_adr;
        w_cs          = '0;
        w_dat         = '0;
        w_ack         = 1'b0;
        w_err         = 1'b0;
        w_adr_err     = 1'b0;
        w_tmo         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_sel_nxt   = w_win;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_err_adr_nxt = bus.m_adr;
                        w_state_nxt   = S_ERR;
                    end
                end
            end

            S_ACTIVE: begin
                w_dat = w_sdat[r_sel];
                if (!bus.m_cyc) begin
                    // Master abandoned the cycle: leave quietly.
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cs[r_sel] = bus.m_stb;
                    w_ack       = w_sack;
                    w_err       = w_serr;
                    if (w_sack | w_serr) begin
                        // A real response always beats the watchdog.
                        w_state_nxt = S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_err         = 1'b1;
                        w_tmo         = 1'b1;
                        w_err_adr_nxt = bus.m_adr;
                        w_state_nxt   = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            S_ERR: begin
                w_err       = 1'b1;
                w_adr_err   = 1'b1;
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cs    = w_cs;
    assign bus.m_dat = w_dat;
    assign bus.m_ack = w_ack;
    assign bus.m_err = w_err;
    assign adr_err_o = w_adr_err;
    assign timeout_o = w_tmo;
    assign err_adr_o = r_err_adr;

endmodule

// File: tb/tb_pbus_decoder_fsm.sv
// Bench for pbus_decoder_fsm: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-level
// model of the decoder (decode by arithmetic over the address map, a wait-age
// count, and the last error address).
module tb_pbus_decoder_fsm;

    localparam int N   = 8;
    localparam int TMO = 4;
    localparam logic [32*N-1:0] BASES = {32'h7000_0000, 32'h6000_0000, 32'h1000_0000, 32'h4000_0000,
                                         32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [32*N-1:0] MASKS = {32'hFF00_0000, {7{32'hF000_0000}}};

    // Transaction phases of the model.
    localparam int TX_NONE   = 0;
    localparam int TX_WAIT   = 1;
    localparam int TX_BADADR = 2;
    localparam int TX_GAP    = 3;

    logic        clk;
    logic        rst_n;
    logic        adr_err;
    logic        tmo;
    logic [31:0] err_adr;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc_no   = 0;

    int          md;
    int          msel;
    int          mage;
    logic [31:0] meadr;

    pbus_decoder_fsm_if #(.N_SLAVES(N)) bus ();

    pbus_decoder_fsm #(
        .N_SLAVES  (N),
        .SLAVE_BASE(BASES),
        .SLAVE_MASK(MASKS),
        .TIMEOUT   (TMO),
        .CNT_W     (8)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .bus      (bus),
        .adr_err_o(adr_err),
        .timeout_o(tmo),
        .err_adr_o(err_adr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc_no);
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_no, act, exp);
        end
    endtask

    // Lowest-index slave whose masked base equals the masked address, or -1.
    function automatic int decode(input logic [31:0] adr);
        int w;
        w = -1;
        for (int i = N - 1; i >= 0; i--)
            if ((adr & MASKS[32*i +: 32]) == (BASES[32*i +: 32] & MASKS[32*i +: 32])) w = i;
        return w;
    endfunction

    // Compare every output against the model, away from the active edge.
    task automatic settle();
        logic [7:0]  ecs;
        logic [31:0] edat;
        logic        eack, eerr, eae, eto;
        @(negedge clk);
        ecs = '0; edat = '0; eack = 1'b0; eerr = 1'b0; eae = 1'b0; eto = 1'b0;
        if (rst_n) begin
            if (md == TX_WAIT) begin
                edat = bus.s_dat[32*msel +: 32];
                if (bus.m_cyc) begin
                    ecs[msel] = bus.m_stb;
                    eack      = bus.s_ack[msel];
                    eto       = !bus.s_ack[msel] && !bus.s_err[msel] && (mage == TMO - 1);
                    eerr      = bus.s_err[msel] | eto;
                end
            end else if (md == TX_BADADR) begin
                eerr = 1'b1;
                eae  = 1'b1;
            end
        end
        chk("m_cs",      bus.cs,    ecs);
        chk("m_dat",     bus.m_dat, edat);
        chk("m_ack",     bus.m_ack, eack);
        chk("m_err",     bus.m_err, eerr);
        chk("m_adr_err", adr_err,   eae);
        chk("m_timeout", tmo,       eto);
        chk("m_err_adr", err_adr,   meadr);
    endtask

    // Advance the model on the clock edge, then release for new stimulus.
    task automatic tick();
        int w;
        @(posedge clk);
        if (!rst_n) begin
            md = TX_NONE; msel = 0; mage = 0; meadr = '0;
        end else begin
            case (md)
                TX_NONE: if (bus.m_cyc && bus.m_stb) begin
                    w = decode(bus.m_adr);
                    if (w >= 0) begin md = TX_WAIT; msel = w; mage = 0; end
                    else begin md = TX_BADADR; meadr = bus.m_adr; end
                end
                TX_WAIT: begin
                    if (!bus.m_cyc) md = TX_NONE;
                    else if (bus.s_ack[msel] || bus.s_err[msel]) md = TX_GAP;
                    else if (mage == TMO - 1) begin md = TX_GAP; meadr = bus.m_adr; end
                    else mage++;
                end
                TX_BADADR: md = TX_GAP;
                default:   md = TX_NONE;
            endcase
        end
        #1;
        cyc_no++;
    endtask

    task automatic start(input logic [31:0] adr);
        bus.m_adr = adr; bus.m_cyc = 1'b1; bus.m_stb = 1'b1;
        bus.s_ack = '0;  bus.s_err = '0;
    endtask

    task automatic drop();
        bus.m_cyc = 1'b0; bus.m_stb = 1'b0; bus.s_ack = '0; bus.s_err = '0;
        settle(); tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.m_adr = '0; bus.m_cyc = 1'b0; bus.m_stb = 1'b0;
        bus.s_dat = '0; bus.s_ack = '0; bus.s_err = '0;
        md = TX_NONE; msel = 0; mage = 0; meadr = '0;
        for (int i = 0; i < N; i++) bus.s_dat[32*i +: 32] = 32'hD000_0000 | i;

        // Reset state.
        settle();
        chk("rst_cs", bus.cs, 0);
        chk("rst_err_adr", err_adr, 0);
        tick();
        rst_n = 1'b1;
        settle(); tick();

        // Map hit on slave 2, ack two cycles after cs.
        start(32'h2000_0010);
        settle(); chk("hit_c0_cs", bus.cs, 0); tick();
        settle(); chk("hit_c1_cs", bus.cs, 8'h04); tick();
        settle(); tick();
        bus.s_dat[95:64] = 32'hCAFE_0002; bus.s_ack = 8'h04;
        settle(); chk("hit_c3_ack", bus.m_ack, 1); chk("hit_c3_dat", bus.m_dat, 32'hCAFE_0002); tick();
        bus.s_ack = '0;
        settle(); chk("hit_done_cs", bus.cs, 0); chk("hit_done_ack", bus.m_ack, 0); tick();
        drop();

        // Unmapped address.
        start(32'hE000_0000);
        settle(); tick();
        settle(); chk("unm_err", bus.m_err, 1); chk("unm_adr_err", adr_err, 1); chk("unm_cs", bus.cs, 0); tick();
        settle(); chk("unm_err_clr", bus.m_err, 0); chk("unm_err_adr", err_adr, 32'hE000_0000); tick();
        drop();

        // Watchdog timeout on slave 3.
        start(32'h3000_0000);
        settle(); tick();
        for (int k = 1; k <= TMO; k++) begin
            settle();
            chk("tmo_cs", bus.cs, 8'h08);
            chk("tmo_pulse", tmo, (k == TMO) ? 1 : 0);
            chk("tmo_err", bus.m_err, (k == TMO) ? 1 : 0);
            tick();
        end
        settle(); chk("tmo_cs_drop", bus.cs, 0); chk("tmo_err_adr", err_adr, 32'h3000_0000); tick();
        drop();

        // Ack coinciding with the last wait cycle.
        start(32'h3000_0040);
        settle(); tick();
        for (int k = 1; k < TMO; k++) begin settle(); tick(); end
        bus.s_ack = 8'h08;
        settle(); chk("col_ack", bus.m_ack, 1); chk("col_err", bus.m_err, 0); chk("col_tmo", tmo, 0); tick();
        drop(); drop();

        // Overlapping maps: slave 1 wins, slave 5 ack ignored.
        start(32'h1000_0000);
        settle(); tick();
        bus.s_ack = 8'h20;
        settle(); chk("ovl_cs", bus.cs, 8'h02); chk("ovl_ack5", bus.m_ack, 0); tick();
        bus.s_ack = 8'h02;
        settle(); chk("ovl_cs2", bus.cs, 8'h02); chk("ovl_ack1", bus.m_ack, 1); tick();
        drop();

        // Abort by dropping cyc, then async reset mid-ACTIVE.
        start(32'h4000_0000);
        settle(); tick();
        settle(); chk("abt_cs", bus.cs, 8'h10); tick();
        bus.m_cyc = 1'b0; bus.s_ack = 8'h10;
        settle(); chk("abt_ack", bus.m_ack, 0); chk("abt_cs0", bus.cs, 0); tick();
        bus.m_cyc = 1'b1; bus.s_ack = '0;
        settle(); chk("abt_idle_cs", bus.cs, 0); tick();
        settle(); chk("abt_re_cs", bus.cs, 8'h10); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cs", bus.cs, 0);
        chk("arst_err_adr", err_adr, 0);
        md = TX_NONE; meadr = '0;
        settle(); tick();
        rst_n = 1'b1;
        drop();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.m_cyc = ($urandom_range(7) != 0);
            bus.m_stb = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) bus.m_adr = $urandom;
            for (int i = 0; i < N; i++) begin
                bus.s_ack[i] = ($urandom_range(4) == 0);
                bus.s_err[i] = ($urandom_range(11) == 0);
                bus.s_dat[32*i +: 32] = $urandom;
            end
            settle(); tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
